// File: rtl/rc4_stream_encryptor.sv
// RC4 stream encryptor: runs INIT + key schedule in an external single-port
// S RAM, then turns each accepted plaintext byte into one ciphertext byte.
`timescale 1ns/1ps
module rc4_stream_encryptor #(
   parameter int KEY_BYTES = 3
) (
   input  logic                   CLOCK_50,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   output logic                   busy,
   output logic                   key_ready,
   input  logic [7:0]             pt_data,
   input  logic                   pt_valid,
   output logic                   pt_ready,
   output logic [7:0]             ct_data,
   output logic                   ct_valid,
   input  logic                   ct_ready,
   output logic [7:0]             s_address,
   output logic [7:0]             s_data,
   output logic                   s_wren,
   input  logic [7:0]             s_q
);

   localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,  ST_INIT   = 4'd1,  ST_K_RD_I = 4'd2,  ST_K_RD_J = 4'd3,
      ST_K_WR_J = 4'd4,  ST_K_WR_I = 4'd5,  ST_ARMED  = 4'd6,  ST_P_RD_I = 4'd7,
      ST_P_RD_J = 4'd8,  ST_P_WR_J = 4'd9,  ST_P_WR_I = 4'd10, ST_P_RD_F = 4'd11,
      ST_P_XOR  = 4'd12, ST_OUT    = 4'd13
   } state_t;

   state_t state_r, state_s;
   logic [7:0] i_r, i_s, j_r, j_s, si_r, si_s, sj_r, sj_s, pt_r, pt_s;
   logic [8*KEY_BYTES-1:0] key_r, key_s;
   logic [KIDX_W-1:0] kidx_r, kidx_s;
   logic [7:0] addr_r, addr_s, wdata_r, wdata_s, ct_data_r, ct_data_s;
   logic wren_r, wren_s, ct_valid_r, ct_valid_s;
   logic busy_r, busy_s, key_ready_r, key_ready_s, pt_ready_r, pt_ready_s;
   logic [7:0] j_ksa_s, j_prga_s;

   function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                           input logic [KIDX_W-1:0] idx);
      logic [7:0] b;
      b = 8'd0;
      for (int n = 0; n < KEY_BYTES; n++) begin
         if (idx == KIDX_W'(n)) b = key[8*(KEY_BYTES-1-n) +: 8];
         else                   b = b;
      end
      return b;
   endfunction

   // s_q carries the byte addressed by the previous state, so j is formed from it directly
   assign j_ksa_s  = j_r + s_q + key_byte(key_r, kidx_r);
   assign j_prga_s = j_r + s_q;

   // State register
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) state_r <= ST_IDLE;
      else          state_r <= state_s;
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:   if (start) state_s = ST_INIT; else state_s = ST_IDLE;
         ST_INIT:   if (i_r == 8'd255) state_s = ST_K_RD_I; else state_s = ST_INIT;
         ST_K_RD_I: state_s = ST_K_RD_J;
         ST_K_RD_J: state_s = ST_K_WR_J;
         ST_K_WR_J: state_s = ST_K_WR_I;
         ST_K_WR_I: if (i_r == 8'd255) state_s = ST_ARMED; else state_s = ST_K_RD_I;
         ST_ARMED: begin
            if (start)         state_s = ST_INIT;
            else if (pt_valid) state_s = ST_P_RD_I;
            else               state_s = ST_ARMED;
         end
         ST_P_RD_I: state_s = ST_P_RD_J;
         ST_P_RD_J: state_s = ST_P_WR_J;
         ST_P_WR_J: state_s = ST_P_WR_I;
         ST_P_WR_I: state_s = ST_P_RD_F;
         ST_P_RD_F: state_s = ST_P_XOR;
         ST_P_XOR:  state_s = ST_OUT;
         ST_OUT:    if (ct_ready) state_s = ST_ARMED; else state_s = ST_OUT;
         default:   state_s = ST_IDLE;
      endcase
   end

   // Datapath and RAM-port next values; all RAM outputs are loaded one cycle ahead
   always_comb begin
      i_s = i_r; j_s = j_r; si_s = si_r; sj_s = sj_r; pt_s = pt_r;
      key_s = key_r; kidx_s = kidx_r;
      addr_s = addr_r; wdata_s = wdata_r; wren_s = 1'b0;
      ct_data_s = ct_data_r; ct_valid_s = ct_valid_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               i_s = 8'd0; j_s = 8'd0; kidx_s = {KIDX_W{1'b0}}; key_s = secret_key;
            end else begin
               key_s = key_r;
            end
         end
         ST_INIT: begin
            addr_s = i_r; wdata_s = i_r; wren_s = 1'b1;
            i_s = i_r + 8'd1;
         end
         ST_K_RD_I: addr_s = i_r;
         ST_K_RD_J: begin
            si_s = s_q; j_s = j_ksa_s; addr_s = j_ksa_s;
         end
         ST_K_WR_J: begin
            sj_s = s_q; addr_s = j_r; wdata_s = si_r; wren_s = 1'b1;
         end
         ST_K_WR_I: begin
            addr_s = i_r; wdata_s = sj_r; wren_s = 1'b1;
            i_s = i_r + 8'd1;
            if (i_r == 8'd255) begin
               j_s = 8'd0; kidx_s = {KIDX_W{1'b0}};
            end else if (kidx_r == KIDX_W'(KEY_BYTES-1)) begin
               kidx_s = {KIDX_W{1'b0}};
            end else begin
               kidx_s = kidx_r + KIDX_W'(1);
            end
         end
         ST_ARMED: begin
            if (start) begin
               i_s = 8'd0; j_s = 8'd0; kidx_s = {KIDX_W{1'b0}}; key_s = secret_key;
            end else if (pt_valid) begin
               pt_s = pt_data; i_s = i_r + 8'd1;
            end else begin
               pt_s = pt_r;
            end
         end
         ST_P_RD_I: addr_s = i_r;
         ST_P_RD_J: begin
            si_s = s_q; j_s = j_prga_s; addr_s = j_prga_s;
         end
         ST_P_WR_J: begin
            sj_s = s_q; addr_s = j_r; wdata_s = si_r; wren_s = 1'b1;
         end
         ST_P_WR_I: begin
            addr_s = i_r; wdata_s = sj_r; wren_s = 1'b1;
         end
         ST_P_RD_F: addr_s = si_r + sj_r;
         ST_P_XOR: begin
            ct_data_s = s_q ^ pt_r; ct_valid_s = 1'b1;
         end
         ST_OUT: begin
            if (ct_ready) ct_valid_s = 1'b0;
            else          ct_valid_s = 1'b1;
         end
         default: wren_s = 1'b0;
      endcase
   end

   // Status flags, decoded from the state being entered so they register cleanly
   always_comb begin
      busy_s = 1'b0; key_ready_s = 1'b0; pt_ready_s = 1'b0;
      case (state_s)
         ST_INIT, ST_K_RD_I, ST_K_RD_J, ST_K_WR_J, ST_K_WR_I: busy_s = 1'b1;
         ST_ARMED: begin
            key_ready_s = 1'b1; pt_ready_s = 1'b1;
         end
         ST_P_RD_I, ST_P_RD_J, ST_P_WR_J, ST_P_WR_I, ST_P_RD_F, ST_P_XOR, ST_OUT:
            key_ready_s = 1'b1;
         default: busy_s = 1'b0;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         i_r <= 8'd0; j_r <= 8'd0; si_r <= 8'd0; sj_r <= 8'd0; pt_r <= 8'd0;
         key_r <= {(8*KEY_BYTES){1'b0}}; kidx_r <= {KIDX_W{1'b0}};
         addr_r <= 8'd0; wdata_r <= 8'd0; wren_r <= 1'b0;
         ct_data_r <= 8'd0; ct_valid_r <= 1'b0;
         busy_r <= 1'b0; key_ready_r <= 1'b0; pt_ready_r <= 1'b0;
      end else begin
         i_r <= i_s; j_r <= j_s; si_r <= si_s; sj_r <= sj_s; pt_r <= pt_s;
         key_r <= key_s; kidx_r <= kidx_s;
         addr_r <= addr_s; wdata_r <= wdata_s; wren_r <= wren_s;
         ct_data_r <= ct_data_s; ct_valid_r <= ct_valid_s;
         busy_r <= busy_s; key_ready_r <= key_ready_s; pt_ready_r <= pt_ready_s;
      end
   end

   assign busy      = busy_r;
   assign key_ready = key_ready_r;
   assign pt_ready  = pt_ready_r;
   assign ct_data   = ct_data_r;
   assign ct_valid  = ct_valid_r;
   assign s_address = addr_r;
   assign s_data    = wdata_r;
   assign s_wren    = wren_r;

endmodule

// File: tb/tb_rc4_stream_encryptor.sv
// Bench for rc4_stream_encryptor: fixed "Key" vectors from a table, round trip,
// backpressure, resets, re-key, and random traffic against an array-based RC4 model.
`timescale 1ns/1ps
module tb_rc4_stream_encryptor;

   logic clk = 1'b0;
   logic reset_n, start, busy, key_ready, pt_valid, pt_ready, ct_valid, ct_ready, s_wren;
   logic [23:0] secret_key;
   logic [7:0] pt_data, ct_data, s_address, s_data, s_q;

   logic [7:0] ram [256];
   logic [7:0] rs [256];
   int ri, rj;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] pt;
      logic [7:0] ct;
      int         stall;
   } vec_t;
   vec_t tbl [9];
   logic [7:0] rt_ct [32];

   rc4_stream_encryptor #(.KEY_BYTES(3)) dut (
      .CLOCK_50(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
      .busy(busy), .key_ready(key_ready), .pt_data(pt_data), .pt_valid(pt_valid),
      .pt_ready(pt_ready), .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
      .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q)
   );

   always #5 clk = ~clk;

   // S RAM: address registered by the DUT, data returned in the following state
   always @(posedge clk) if (s_wren) ram[s_address] <= s_data;
   assign s_q = ram[s_address];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic ref_key(input logic [23:0] key);
      logic [7:0] kb [3];
      logic [7:0] t;
      int j;
      kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
      for (int n = 0; n < 256; n++) rs[n] = 8'(n);
      j = 0;
      for (int n = 0; n < 256; n++) begin
         j = (j + int'(rs[n]) + int'(kb[n % 3])) % 256;
         t = rs[n]; rs[n] = rs[j]; rs[j] = t;
      end
      ri = 0; rj = 0;
   endtask

   task automatic ref_next(output logic [7:0] k);
      logic [7:0] t;
      ri = (ri + 1) % 256;
      rj = (rj + int'(rs[ri])) % 256;
      t = rs[ri]; rs[ri] = rs[rj]; rs[rj] = t;
      k = rs[(int'(rs[ri]) + int'(rs[rj])) % 256];
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_flags"}, {busy, key_ready, pt_ready, ct_valid, s_wren}, 32'd0);
      check({tag, "_ct_data"}, ct_data, 32'd0);
      check({tag, "_ram_port"}, {s_address, s_data}, 32'd0);
   endtask

   // Start a key load; with noise, pt_valid and a stray start are driven during KSA
   task automatic key_load(input logic [23:0] key, input bit noise);
      int n;
      ref_key(key);
      @(negedge clk);
      secret_key = key; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; n = 1;
      check("load_flags", {busy, key_ready}, 32'd2);
      while (!key_ready && n < 1400) begin
         if (noise) begin
            pt_valid = (n > 100 && n < 1200);
            pt_data = 8'($urandom);
            if (n == 500) begin secret_key = 24'($urandom); start = 1'b1; end
            else start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      pt_valid = 1'b0; start = 1'b0; secret_key = key;
      check("key_ready_latency", n, 32'd1281);
      check("armed_flags", {busy, key_ready, pt_ready}, 32'd3);
   endtask

   task automatic xfer(input logic [7:0] pt, input logic [7:0] exp, input int stall,
                       input string tag);
      int n;
      n = 0;
      while (!pt_ready && n < 64) begin @(posedge clk); #1; n++; end
      check({tag, "_pt_ready"}, pt_ready, 32'd1);
      @(negedge clk);
      pt_data = pt; pt_valid = 1'b1; ct_ready = (stall == 0);
      @(posedge clk); #1;
      pt_valid = 1'b0; pt_data = 8'($urandom); n = 1;
      while (!ct_valid && n < 64) begin @(posedge clk); #1; n++; end
      check({tag, "_ct"}, ct_data, exp);
      check({tag, "_lat_valid"}, n, 32'd7);
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         n++;
         check({tag, "_stall_hold"}, {ct_valid, ct_data, pt_ready}, {22'd0, 1'b1, exp, 1'b0});
      end
      if (stall > 0) begin
         @(negedge clk);
         ct_ready = 1'b1;
      end
      while (!pt_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (stall == 0) check({tag, "_lat_ready"}, n, 32'd8);
      check({tag, "_ct_valid_drop"}, ct_valid, 32'd0);
   endtask

   initial begin
      logic [7:0] k, p;
      logic [23:0] rk;
      tbl[0] = '{8'h50, 8'hBB, 0};  tbl[1] = '{8'h6C, 8'hF3, 0};
      tbl[2] = '{8'h61, 8'h16, 0};  tbl[3] = '{8'h69, 8'hE8, 50};
      tbl[4] = '{8'h6E, 8'hD9, 0};  tbl[5] = '{8'h74, 8'h40, 0};
      tbl[6] = '{8'h65, 8'hAF, 0};  tbl[7] = '{8'h78, 8'h0A, 0};
      tbl[8] = '{8'h74, 8'hD3, 0};

      reset_n = 1'b1; start = 1'b0; secret_key = 24'd0;
      pt_data = 8'd0; pt_valid = 1'b0; ct_ready = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      @(negedge clk) reset_n = 1'b1;

      // pt_valid while IDLE must be ignored
      pt_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_ignore", {busy, key_ready, pt_ready, ct_valid}, 32'd0);
      pt_valid = 1'b0;

      key_load(24'h4B6579, 1'b0);
      for (int v = 0; v < 9; v++) xfer(tbl[v].pt, tbl[v].ct, tbl[v].stall, "key_vec");

      key_load(24'h4B6579, 1'b0);
      for (int v = 0; v < 4; v++) xfer(tbl[v].pt, tbl[v].ct, 0, "rekey_pre");
      key_load(24'h4B6579, 1'b1);
      for (int v = 0; v < 9; v++) xfer(tbl[v].pt, tbl[v].ct, 0, "rekey_post");

      // Reset 700 cycles into a key load
      @(negedge clk);
      secret_key = 24'h4B6579; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (699) @(posedge clk);
      #1 reset_n = 1'b0;
      #1 check_reset("mid_ksa_reset");
      repeat (2) @(posedge clk);
      #1 check_reset("mid_ksa_hold");
      @(negedge clk) reset_n = 1'b1;
      key_load(24'h4B6579, 1'b0);
      xfer(tbl[0].pt, tbl[0].ct, 0, "after_reset");

      key_load(24'h000249, 1'b0);
      for (int v = 0; v < 32; v++) begin
         ref_next(k);
         rt_ct[v] = 8'(v) ^ k;
         xfer(8'(v), rt_ct[v], 0, "rt_enc");
      end
      key_load(24'h000249, 1'b0);
      for (int v = 0; v < 32; v++) xfer(rt_ct[v], 8'(v), 0, "rt_dec");

      for (int r = 0; r < 3; r++) begin
         rk = 24'($urandom);
         key_load(rk, 1'b1);
         for (int v = 0; v < 20; v++) begin
            p = 8'($urandom);
            ref_next(k);
            xfer(p, p ^ k, int'($urandom_range(0, 3)), "rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
